// File: rtl/branch_resolve_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve_if                                                          |
// | Request/response bundle between the pipeline and branch_resolve_unit.      |
// | Optional statistics ports are present only when BR_STATS_EN is defined.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface branch_resolve_if #(
   parameter int CNT_W = 16
);
   logic [2:0]  NZP;
   logic [15:0] IR;
   logic [15:0] PC;
   logic        br_valid;
   logic        br_ready;
   logic        pc_valid;
   logic        pc_ack;
   logic        take;
   logic [15:0] target;
   logic        BEN;

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("branch_resolve_if: CNT_W must be at least 1");
   end

`ifdef BR_STATS_EN
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] taken_count;

   modport master (
      output NZP, IR, PC, br_valid, pc_ack,
      input  br_ready, pc_valid, take, target, BEN, br_count, taken_count
   );
   modport slave (
      input  NZP, IR, PC, br_valid, pc_ack,
      output br_ready, pc_valid, take, target, BEN, br_count, taken_count
   );
`else
   modport master (
      output NZP, IR, PC, br_valid, pc_ack,
      input  br_ready, pc_valid, take, target, BEN
   );
   modport slave (
      input  NZP, IR, PC, br_valid, pc_ack,
      output br_ready, pc_valid, take, target, BEN
   );
`endif
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve_unit                                                        |
// | Three-state BR resolver: capture IR/PC/NZP, evaluate BEN and target,       |
// | hold the result until acknowledged. Optional macro: BR_STATS_EN adds       |
// | saturating br_count/taken_count statistics.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_resolve_unit #(
   parameter int CNT_W = 16
) (
   input logic             clk,
   input logic             rst,
   branch_resolve_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EVAL = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_ir;
   logic [15:0] r_pc;
   logic [2:0]  r_nzp;
   logic [15:0] r_target;
   logic        r_ben;
   logic        r_take;
   logic        r_pc_valid;

   logic        w_ben;
   logic [15:0] w_br_target;

   if (CNT_W < 1) begin : g_cnt_w_check
      $error("branch_resolve_unit: CNT_W must be at least 1");
   end

   // Only opcode 0000 (BR) can branch; the nzp field masks the captured flags.
   always_comb begin
      w_ben       = (r_ir[15:12] == 4'b0000) && (|(r_ir[11:9] & r_nzp));
      w_br_target = r_pc + {{7{r_ir[8]}}, r_ir[8:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ir       <= 16'h0000;
         r_pc       <= 16'h0000;
         r_nzp      <= 3'b000;
         r_target   <= 16'h0000;
         r_ben      <= 1'b0;
         r_take     <= 1'b0;
         r_pc_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.br_valid) begin
                  r_ir    <= bus.IR;
                  r_pc    <= bus.PC;
                  r_nzp   <= bus.NZP;
                  r_state <= S_EVAL;
               end
            end
            S_EVAL: begin
               r_ben      <= w_ben;
               r_take     <= w_ben;
               r_target   <= w_ben ? w_br_target : r_pc;
               r_pc_valid <= 1'b1;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               if (bus.pc_ack) begin
                  r_pc_valid <= 1'b0;
                  r_take     <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.br_ready = (r_state == S_IDLE);
   assign bus.pc_valid = r_pc_valid;
   assign bus.take     = r_take;
   assign bus.target   = r_target;
   assign bus.BEN      = r_ben;

`ifdef BR_STATS_EN
   logic [CNT_W-1:0] r_br_count;
   logic [CNT_W-1:0] r_taken_count;

   // Counted on the acknowledge edge so an aborted resolution never counts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_count    <= '0;
         r_taken_count <= '0;
      end else if ((r_state == S_RESP) && bus.pc_ack) begin
         if (r_br_count != '1) begin
            r_br_count <= r_br_count + 1'b1;
         end
         if (r_take && (r_taken_count != '1)) begin
            r_taken_count <= r_taken_count + 1'b1;
         end
      end
   end

   assign bus.br_count    = r_br_count;
   assign bus.taken_count = r_taken_count;
`endif
endmodule
`default_nettype wire
